// File: rtl/kyber_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kyber_pkg
// Description : Shared Kyber types: BRAM port-B widths, arbiter states, read tags.
// Revision    : 1.0
// ============================================================================
package kyber_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam int WE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic logic [1:0] tag_onehot(input rd_tag_t t);
        return t.valid ? (t.id ? 2'b10 : 2'b01) : 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kyber_bram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : kyber_bram_arb_if
// Description : Requester-side bus of the port-B arbiter (two beat channels).
// Revision    : 1.0
// ============================================================================
interface kyber_bram_arb_if #(
    parameter int ADDR_W = kyber_pkg::ADDR_W,
    parameter int DATA_W = kyber_pkg::DATA_W,
    parameter int WE_W   = kyber_pkg::WE_W
);
    logic [1:0]        req_i;
    logic [1:0]        last_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [WE_W-1:0]   we0_i;
    logic [WE_W-1:0]   we1_i;
    logic [DATA_W-1:0] wrdata0_i;
    logic [DATA_W-1:0] wrdata1_i;
    logic [1:0]        gnt_o;
    logic [1:0]        rvalid_o;
    logic [DATA_W-1:0] rddata_o;

    modport master (
        output req_i, last_i, addr0_i, addr1_i, we0_i, we1_i, wrdata0_i, wrdata1_i,
        input  gnt_o, rvalid_o, rddata_o
    );

    modport slave (
        input  req_i, last_i, addr0_i, addr1_i, we0_i, we1_i, wrdata0_i, wrdata1_i,
        output gnt_o, rvalid_o, rddata_o
    );
endinterface
`default_nettype wire

// File: rtl/kyber_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : kyber_rd_tag_pipe
// Description : Delays {valid, id} of each accepted beat to the read-data cycle.
// Revision    : 1.0
// ============================================================================
module kyber_rd_tag_pipe #(
    parameter int RD_LAT = 1
) (
    input  wire logic reg_clk,
    input  wire logic reg_rst,
    input  wire logic push_valid_i,
    input  wire logic push_id_i,
    output logic [1:0] rvalid_o
);
    import kyber_pkg::*;

    // Stage 0 lines up with the BRAM command cycle; stage RD_LAT with read data.
    rd_tag_t tag_q [RD_LAT+1];

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= push_valid_i;
            tag_q[0].id    <= push_id_i;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rvalid_o = tag_onehot(tag_q[RD_LAT]);

endmodule
`default_nettype wire

// File: rtl/kyber_bram_arb.sv
`default_nettype none
// ============================================================================
// Module      : kyber_bram_arb
// Description : Round-robin burst-locking arbiter for the shared 128-bit BRAM port B.
// Revision    : 1.0
// ============================================================================
module kyber_bram_arb #(
    parameter int ADDR_W    = kyber_pkg::ADDR_W,
    parameter int DATA_W    = kyber_pkg::DATA_W,
    parameter int WE_W      = kyber_pkg::WE_W,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  wire logic              reg_clk,
    input  wire logic              reg_rst,
    kyber_bram_arb_if.slave        bus,
    output logic [ADDR_W-1:0]      addr_br,
    output logic                   en_br,
    output logic [WE_W-1:0]        we_br,
    output logic [DATA_W-1:0]      wrdata_br,
    input  wire logic [DATA_W-1:0] rddata_br
);
    import kyber_pkg::*;

    arb_state_t        state_q;
    logic              prio_q;
    logic              bubble_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              en_q;
    logic [WE_W-1:0]   we_q;
    logic [DATA_W-1:0] wrdata_q;

    logic [1:0]        gnt;
    logic              win_id;
    logic              acc;
    logic              acc_id;
    logic              acc_last;
    logic              own_id;
    logic              burst_done;
    logic [8:0]        beats_after;
    logic [ADDR_W-1:0] beat_addr;
    logic [WE_W-1:0]   beat_we;
    logic [DATA_W-1:0] beat_data;

    // Grant never looks at last_i; the bubble cycle after an owned burst grants nobody.
    always_comb begin
        win_id = (bus.req_i == 2'b11) ? prio_q : bus.req_i[1];
        gnt    = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (!bubble_q && (bus.req_i != 2'b00)) begin
                    gnt = win_id ? 2'b10 : 2'b01;
                end
            end
            ST_OWN0: gnt = {1'b0, bus.req_i[0]};
            ST_OWN1: gnt = {bus.req_i[1], 1'b0};
            default: gnt = 2'b00;
        endcase
    end

    assign acc         = |gnt;
    assign acc_id      = gnt[1];
    assign own_id      = (state_q == ST_OWN1);
    assign acc_last    = bus.last_i[acc_id];
    assign beat_addr   = acc_id ? bus.addr1_i   : bus.addr0_i;
    assign beat_we     = acc_id ? bus.we1_i     : bus.we0_i;
    assign beat_data   = acc_id ? bus.wrdata1_i : bus.wrdata0_i;
    // The count restarts with every grant out of IDLE, so that beat is beat number one.
    assign beats_after = (state_q == ST_IDLE) ? 9'd1 : ({1'b0, cnt_q} + 9'd1);
    assign burst_done  = acc_last || (beats_after == 9'(MAX_BURST));

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state_q  <= ST_IDLE;
            prio_q   <= 1'b0;
            bubble_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            en_q     <= 1'b0;
            we_q     <= '0;
            wrdata_q <= '0;
        end else begin
            en_q     <= acc;
            we_q     <= acc ? beat_we : '0;
            bubble_q <= 1'b0;
            if (acc) begin
                addr_q   <= beat_addr;
                wrdata_q <= beat_data;
                cnt_q    <= beats_after[7:0];
            end
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        if (burst_done) begin
                            prio_q <= ~acc_id;
                        end else begin
                            state_q <= acc_id ? ST_OWN1 : ST_OWN0;
                        end
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    // No accept while owning means the owner dropped its request.
                    if (!acc || burst_done) begin
                        state_q  <= ST_IDLE;
                        prio_q   <= ~own_id;
                        bubble_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    kyber_rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .reg_clk      (reg_clk),
        .reg_rst      (reg_rst),
        .push_valid_i (acc && (beat_we == '0)),
        .push_id_i    (acc_id),
        .rvalid_o     (bus.rvalid_o)
    );

    assign bus.gnt_o    = gnt;
    assign bus.rddata_o = rddata_br;
    assign addr_br      = addr_q;
    assign en_br        = en_q;
    assign we_br        = we_q;
    assign wrdata_br    = wrdata_q;

endmodule
`default_nettype wire

// File: tb/tb_kyber_bram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_kyber_bram_arb
// Description : Scoreboard bench: arbitration model, command and read-return queues.
// Revision    : 1.0
// ============================================================================
module tb_kyber_bram_arb;
    import kyber_pkg::*;

    localparam int RD_LAT    = 3;
    localparam int MAX_BURST = 4;
    localparam int AW        = 8;
    localparam int DW        = 128;
    localparam int WW        = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kyber_bram_arb_if #(.ADDR_W(AW), .DATA_W(DW), .WE_W(WW)) bus ();

    logic [AW-1:0] addr_br;
    logic          en_br;
    logic [WW-1:0] we_br;
    logic [DW-1:0] wrdata_br;
    logic [DW-1:0] rddata_br;

    kyber_bram_arb #(
        .ADDR_W(AW), .DATA_W(DW), .WE_W(WW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .reg_clk   (clk),
        .reg_rst   (rst),
        .bus       (bus),
        .addr_br   (addr_br),
        .en_br     (en_br),
        .we_br     (we_br),
        .wrdata_br (wrdata_br),
        .rddata_br (rddata_br)
    );

    // Requester drive variables
    logic          req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [WW-1:0] w0 = '0, w1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;

    assign bus.req_i     = {req1, req0};
    assign bus.last_i    = {last1, last0};
    assign bus.addr0_i   = a0;
    assign bus.addr1_i   = a1;
    assign bus.we0_i     = w0;
    assign bus.we1_i     = w1;
    assign bus.wrdata0_i = d0;
    assign bus.wrdata1_i = d1;

    function automatic logic [DW-1:0] pat(input int i);
        return {32'(i) ^ 32'hA5A5_0000, 32'(i) * 32'h9E37_79B9, ~32'(i), 32'(i) + 32'h0101_0101};
    endfunction

    // BRAM model: read-first, RD_LAT cycles from en_br to rddata_br
    logic [DW-1:0] bram  [256];
    logic [DW-1:0] rpipe [RD_LAT];
    logic          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) bram[i] <= pat(i);
            init_done <= 1'b1;
        end else if (en_br === 1'b1) begin
            for (int i = 0; i < WW; i++) begin
                if (we_br[i]) bram[addr_br][8*i +: 8] <= wrdata_br[8*i +: 8];
            end
        end
        rpipe[0] <= bram[addr_br];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rddata_br = rpipe[RD_LAT-1];

    // Scoreboard
    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        logic [DW-1:0] d;
    } cmd_t;
    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } rd_t;

    cmd_t cmdq[$];
    rd_t  rdq[2][$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, exp);
        end
    endtask

    // Reference model: who owns the port, beats taken, pending bubble, priority
    int            m_owner  = -1;
    int            m_beats  = 0;
    bit            m_bubble = 1'b0;
    bit            m_prio   = 1'b0;
    logic [DW-1:0] refm [256];

    initial begin
        logic [1:0]    rq, g;
        int            w;
        logic [AW-1:0] ba;
        logic [WW-1:0] bw;
        logic [DW-1:0] bd;
        for (int i = 0; i < 256; i++) refm[i] = pat(i);
        forever begin
            @(posedge clk);
            #3;
            rq = bus.req_i;
            if (rst) begin
                m_owner = -1; m_beats = 0; m_bubble = 1'b0; m_prio = 1'b0;
                while (cmdq.size() > 0 && cmdq[cmdq.size()-1].cyc > cyc) cmdq.delete(cmdq.size()-1);
                for (int k = 0; k < 2; k++) begin
                    while (rdq[k].size() > 0 && rdq[k][rdq[k].size()-1].cyc > cyc) rdq[k].delete(rdq[k].size()-1);
                end
                continue;
            end
            g = 2'b00;
            if (m_owner >= 0) begin
                g[m_owner] = rq[m_owner];
            end else if (!m_bubble && rq != 2'b00) begin
                w = (rq == 2'b11) ? int'(m_prio) : (rq[1] ? 1 : 0);
                g[w] = 1'b1;
            end
            chk("gnt", DW'(bus.gnt_o), DW'(g));
            if (m_owner < 0) m_bubble = 1'b0;
            if (g != 2'b00) begin
                w  = g[1] ? 1 : 0;
                ba = w ? a1 : a0;
                bw = w ? w1 : w0;
                bd = w ? d1 : d0;
                cmdq.push_back('{cyc: cyc + 1, a: ba, w: bw, d: bd});
                if (bw == '0) begin
                    rdq[w].push_back('{cyc: cyc + 1 + RD_LAT, d: refm[ba]});
                end else begin
                    for (int i = 0; i < WW; i++) if (bw[i]) refm[ba][8*i +: 8] = bd[8*i +: 8];
                end
                m_beats = (m_owner < 0) ? 1 : m_beats + 1;
                if (bus.last_i[w] || m_beats == MAX_BURST) begin
                    if (m_owner >= 0) m_bubble = 1'b1;
                    m_owner = -1;
                    m_prio  = (w == 0);
                end else begin
                    m_owner = w;
                end
            end else if (m_owner >= 0) begin
                m_prio   = (m_owner == 0);
                m_owner  = -1;
                m_bubble = 1'b1;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a command or read data
    cmd_t mc;
    rd_t  mr;
    initial begin
        forever begin
            @(negedge clk);
            if (en_br === 1'b1) begin
                checks++;
                if (cmdq.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected cyc=%0d got addr=%h we=%h want no command", cyc, addr_br, we_br);
                end else begin
                    mc = cmdq.pop_front();
                    if (mc.cyc != cyc || addr_br !== mc.a || we_br !== mc.w || wrdata_br !== mc.d) begin
                        errors++;
                        $display("FAIL cmd cyc=%0d got a=%h we=%h d=%h want cyc=%0d a=%h we=%h d=%h",
                                 cyc, addr_br, we_br, wrdata_br, mc.cyc, mc.a, mc.w, mc.d);
                    end
                end
            end else begin
                chk("idle_we", DW'(we_br), '0);
                checks++;
                if (cmdq.size() > 0 && cmdq[0].cyc <= cyc) begin
                    errors++;
                    $display("FAIL cmd_missing cyc=%0d got en=%b want en=1 addr=%h", cyc, en_br, cmdq[0].a);
                    void'(cmdq.pop_front());
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (bus.rvalid_o[k] !== 1'b0) begin
                    checks++;
                    if (rdq[k].size() == 0) begin
                        errors++;
                        $display("FAIL rvalid_unexpected id=%0d cyc=%0d got rvalid=%b want 0", k, cyc, bus.rvalid_o[k]);
                    end else begin
                        mr = rdq[k].pop_front();
                        if (mr.cyc != cyc || bus.rddata_o !== mr.d) begin
                            errors++;
                            $display("FAIL rdata id=%0d got cyc=%0d d=%h want cyc=%0d d=%h",
                                     k, cyc, bus.rddata_o, mr.cyc, mr.d);
                        end
                    end
                end else if (rdq[k].size() > 0 && rdq[k][0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_missing id=%0d cyc=%0d got 0 want 1 at cyc %0d", k, cyc, rdq[k][0].cyc);
                    void'(rdq[k].pop_front());
                end
            end
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 after the beat is taken
    task automatic set_drv(input int k, input logic r, input logic [AW-1:0] a,
                           input logic [WW-1:0] w, input logic [DW-1:0] d, input logic l);
        if (k == 0) begin req0 = r; a0 = a; w0 = w; d0 = d; last0 = l; end
        else        begin req1 = r; a1 = a; w1 = w; d1 = d; last1 = l; end
    endtask

    task automatic idle(input int k);
        if (k == 0) begin req0 = 1'b0; last0 = 1'b0; end
        else        begin req1 = 1'b0; last1 = 1'b0; end
    endtask

    task automatic do_beat(input int k, input logic [AW-1:0] a, input logic [WW-1:0] w,
                           input logic [DW-1:0] d, input logic l);
        int t = 0;
        set_drv(k, 1'b1, a, w, d, l);
        forever begin
            @(negedge clk);
            if (bus.gnt_o[k] === 1'b1) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL grant_timeout id=%0d got no grant want grant within 200 cycles", k);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int k, input int n, input bit no_last, input logic [AW-1:0] base);
        logic [WW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(0, 1) == 1) ? (WW'($urandom) | WW'(1)) : '0;
            do_beat(k, base + AW'(i), w, {$urandom, $urandom, $urandom, $urandom}, !no_last && (i == n - 1));
        end
        idle(k);
    endtask

    task automatic rnd_traffic(input int k);
        int n;
        logic [WW-1:0] w;
        for (int b = 0; b < 30; b++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 9) == 0) break;
                w = ($urandom_range(0, 1) == 1) ? (WW'($urandom) | WW'(1)) : '0;
                do_beat(k, AW'($urandom_range(0, 31)), w, {$urandom, $urandom, $urandom, $urandom}, i == n - 1);
            end
            idle(k);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic check_reset_vals();
        @(negedge clk);
        chk("rst_gnt",    DW'(bus.gnt_o),    '0);
        chk("rst_rvalid", DW'(bus.rvalid_o), '0);
        chk("rst_en",     DW'(en_br),        '0);
        chk("rst_we",     DW'(we_br),        '0);
        chk("rst_addr",   DW'(addr_br),      '0);
        chk("rst_wrdata", wrdata_br,         '0);
    endtask

    initial begin
        logic [DW-1:0] data_a;
        data_a = {4{32'hA5A5_5A5A}};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals();
        @(posedge clk); #1;

        // Single read
        do_beat(0, 8'h05, '0, '0, 1'b1);
        idle(0);
        repeat (6) begin @(posedge clk); #1; end

        // Contention: both request in the same cycle
        fork
            burst(0, 3, 1'b0, 8'h20);
            burst(1, 2, 1'b0, 8'h30);
        join
        repeat (2) begin @(posedge clk); #1; end

        // Forced release: a long unterminated stream against a waiting requester
        fork
            burst(1, 10, 1'b1, 8'h40);
            begin @(posedge clk); #1; burst(0, 2, 1'b0, 8'h50); end
        join
        repeat (2) begin @(posedge clk); #1; end

        // Write then read back the same word
        do_beat(0, 8'h10, 16'hFFFF, data_a, 1'b0);
        do_beat(0, 8'h10, '0, '0, 1'b1);
        idle(0);
        repeat (6) begin @(posedge clk); #1; end

        // Reset with two reads in flight
        do_beat(0, 8'h05, '0, '0, 1'b0);
        do_beat(0, 8'h06, '0, '0, 1'b0);
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_vals();
        repeat (6) begin @(posedge clk); #1; end

        // Abandoned burst while the other requester waits
        fork
            begin
                do_beat(0, 8'h70, '0, '0, 1'b0);
                do_beat(0, 8'h71, '0, '0, 1'b0);
                idle(0);
            end
            begin @(posedge clk); #1; burst(1, 2, 1'b0, 8'h60); end
        join
        repeat (2) begin @(posedge clk); #1; end

        // Random traffic from both requesters
        fork
            rnd_traffic(0);
            rnd_traffic(1);
        join

        repeat (RD_LAT + 4) @(posedge clk);
        @(negedge clk);
        chk("drain_cmd", DW'(cmdq.size()),   '0);
        chk("drain_rd0", DW'(rdq[0].size()), '0);
        chk("drain_rd1", DW'(rdq[1].size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no end of test want finish before 400000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
